parking_exit_controller: RTL and testbench

- Handles the out_mode (car retrieval) path of the parking lot, the counterpart to the entry path that writes plates into slots.
- On an exit request it searches the slot table for the license plate, then drives the elevator to that floor.
- At the floor it clears the slot and carries the car down to ground, then reports the fee.
- Sits between the top-level request inputs, the shared slot table (read port plus clear port), and the fee/elevator outputs.

---
 rtl/parking_pkg.sv | 28 ++
 rtl/parking_exit_if.sv | 35 +++
 rtl/exit_fee_calc.sv | 29 ++
 rtl/parking_exit_controller.sv | 185 ++++++++++++++++++
 tb/tb_parking_exit_controller.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lot exit path.
package parking_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StTravelUp,
    StHoldCheck,
    StLoad,
    StTravelDown,
    StBill
  } exit_state_e;

  localparam int unsigned SlotAddrW = 4;
  localparam int unsigned FloorW    = 3;
  localparam int unsigned PlateW    = 16;
  localparam int unsigned TimeW     = 16;
  localparam int unsigned SlotW     = 32;

  // Slot word layout: {entry_time, plate}
  localparam int unsigned PlateLsb = 0;
  localparam int unsigned EntryLsb = 16;
  localparam int unsigned SuvBit   = 15;

  localparam logic [PlateW-1:0] PlateEmpty  = 16'h0000;
  localparam logic [FloorW-1:0] GroundFloor = 3'd0;

endpackage

// File: rtl/parking_exit_if.sv
// Request, slot-table and result signals of the exit controller.
interface parking_exit_if;
  import parking_pkg::*;

  logic                 out_mode;
  logic [PlateW-1:0]    license_plate;
  logic                 leakage;
  logic [FloorW-1:0]    leakage_floor;
  logic [TimeW-1:0]     time_now;
  logic                 slot_rd_en;
  logic [SlotAddrW-1:0] slot_rd_addr;
  logic [SlotW-1:0]     slot_rd_data;
  logic                 slot_clr;
  logic [SlotAddrW-1:0] slot_clr_addr;
  logic                 busy;
  logic [FloorW-1:0]    current_floor;
  logic [PlateW-1:0]    moving;
  logic                 plate_type;
  logic [7:0]           fee;
  logic                 done;
  logic                 not_found;

  modport master (
    input  out_mode, license_plate, leakage, leakage_floor, time_now, slot_rd_data,
    output slot_rd_en, slot_rd_addr, slot_clr, slot_clr_addr, busy, current_floor,
    output moving, plate_type, fee, done, not_found
  );

  modport slave (
    output out_mode, license_plate, leakage, leakage_floor, time_now, slot_rd_data,
    input  slot_rd_en, slot_rd_addr, slot_clr, slot_clr_addr, busy, current_floor,
    input  moving, plate_type, fee, done, not_found
  );

endinterface

// File: rtl/exit_fee_calc.sv
// Combinational parking fee: billed units of elapsed time times a per-type rate, saturated.
module exit_fee_calc
  import parking_pkg::*;
#(
  parameter int unsigned UNIT_SHIFT = 4,
  parameter int unsigned SEDAN_RATE = 2,
  parameter int unsigned SUV_RATE   = 3
) (
  input  logic [TimeW-1:0] time_now_i,
  input  logic [TimeW-1:0] entry_time_i,
  input  logic             suv_i,
  output logic [7:0]       fee_o
);

  logic [TimeW-1:0] elapsed;
  logic [TimeW-1:0] units;
  logic [23:0]      rate;
  logic [23:0]      raw;

  always_comb begin
    // Modular subtraction keeps timebase wrap-around correct
    elapsed = time_now_i - entry_time_i;
    units   = elapsed >> UNIT_SHIFT;
    rate    = suv_i ? 24'(SUV_RATE) : 24'(SEDAN_RATE);
    raw     = (24'(units) + 24'd1) * rate;
    fee_o   = (raw > 24'd255) ? 8'hFF : raw[7:0];
  end

endmodule

// File: rtl/parking_exit_controller.sv
// Exit path: find the plate in the slot table, fetch the car, free the slot and bill it.
module parking_exit_controller
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 14,
  parameter int unsigned FLOOR_CYCLES = 4,
  parameter int unsigned UNIT_SHIFT   = 4,
  parameter int unsigned SEDAN_RATE   = 2,
  parameter int unsigned SUV_RATE     = 3
) (
  input  logic           clock_i,
  input  logic           reset_i,
  parking_exit_if.master bus
);

  localparam int unsigned IdxW  = SlotAddrW + 1;
  localparam int unsigned StepW = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;

  exit_state_e          state_q, state_d;
  logic [IdxW-1:0]      rd_idx_q, rd_idx_d;
  logic                 cmp_vld_q, cmp_vld_d;
  logic [SlotAddrW-1:0] cmp_idx_q, cmp_idx_d;
  logic [PlateW-1:0]    plate_q, plate_d;
  logic                 plate_type_q, plate_type_d;
  logic [SlotAddrW-1:0] slot_q, slot_d;
  logic [TimeW-1:0]     entry_q, entry_d;
  logic [FloorW-1:0]    target_q, target_d;
  logic [FloorW-1:0]    floor_q, floor_d;
  logic [StepW-1:0]     step_q, step_d;
  logic [7:0]           fee_load_q, fee_load_d;
  logic [7:0]           fee_q, fee_d;
  logic                 not_found_q, not_found_d;

  logic       hit, issuing, last_miss, step_done, leak_block;
  logic [7:0] fee_calc;

  exit_fee_calc #(
    .UNIT_SHIFT (UNIT_SHIFT),
    .SEDAN_RATE (SEDAN_RATE),
    .SUV_RATE   (SUV_RATE)
  ) u_fee_calc (
    .time_now_i   (bus.time_now),
    .entry_time_i (entry_q),
    .suv_i        (plate_type_q),
    .fee_o        (fee_calc)
  );

  // A hit suppresses the read issued in the same cycle, so no slot past the match is read
  assign hit        = (state_q == StSearch) && cmp_vld_q &&
                      (bus.slot_rd_data[PlateLsb +: PlateW] == plate_q);
  assign issuing    = (state_q == StSearch) && (rd_idx_q < IdxW'(NUM_SLOTS)) && !hit;
  assign last_miss  = (state_q == StSearch) && cmp_vld_q && !hit &&
                      (cmp_idx_q == SlotAddrW'(NUM_SLOTS - 1));
  assign step_done  = (step_q == StepW'(FLOOR_CYCLES - 1));
  assign leak_block = bus.leakage && (bus.leakage_floor == target_q);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      rd_idx_q     <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_idx_q    <= '0;
      plate_q      <= '0;
      plate_type_q <= 1'b0;
      slot_q       <= '0;
      entry_q      <= '0;
      target_q     <= '0;
      floor_q      <= GroundFloor;
      step_q       <= '0;
      fee_load_q   <= '0;
      fee_q        <= '0;
      not_found_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_idx_q    <= cmp_idx_d;
      plate_q      <= plate_d;
      plate_type_q <= plate_type_d;
      slot_q       <= slot_d;
      entry_q      <= entry_d;
      target_q     <= target_d;
      floor_q      <= floor_d;
      step_q       <= step_d;
      fee_load_q   <= fee_load_d;
      fee_q        <= fee_d;
      not_found_q  <= not_found_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    cmp_vld_d    = cmp_vld_q;
    cmp_idx_d    = cmp_idx_q;
    plate_d      = plate_q;
    plate_type_d = plate_type_q;
    slot_d       = slot_q;
    entry_d      = entry_q;
    target_d     = target_q;
    floor_d      = floor_q;
    step_d       = step_q;
    fee_load_d   = fee_load_q;
    fee_d        = fee_q;
    not_found_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.out_mode) begin
          if (bus.license_plate != PlateEmpty) begin
            plate_d      = bus.license_plate;
            plate_type_d = bus.license_plate[SuvBit];
            rd_idx_d     = '0;
            cmp_vld_d    = 1'b0;
            state_d      = StSearch;
          end else begin
            not_found_d = 1'b1;
          end
        end
      end
      StSearch: begin
        cmp_vld_d = issuing;
        cmp_idx_d = rd_idx_q[SlotAddrW-1:0];
        if (issuing) rd_idx_d = rd_idx_q + 1'b1;
        if (hit) begin
          slot_d   = cmp_idx_q;
          entry_d  = bus.slot_rd_data[EntryLsb +: TimeW];
          target_d = FloorW'(cmp_idx_q >> 1) + 3'd1;
          step_d   = '0;
          state_d  = StTravelUp;
        end else if (last_miss) begin
          not_found_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StTravelUp: begin
        if (floor_q == target_q) begin
          state_d = StHoldCheck;
        end else if (step_done) begin
          step_d  = '0;
          floor_d = floor_q + 3'd1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StHoldCheck: begin
        if (!leak_block) state_d = StLoad;
      end
      StLoad: begin
        fee_load_d = fee_calc;
        step_d     = '0;
        state_d    = StTravelDown;
      end
      StTravelDown: begin
        if (floor_q == GroundFloor) begin
          fee_d   = fee_load_q;
          state_d = StBill;
        end else if (step_done) begin
          step_d  = '0;
          floor_d = floor_q - 3'd1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StBill: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.slot_rd_en    = issuing;
    bus.slot_rd_addr  = issuing ? rd_idx_q[SlotAddrW-1:0] : '0;
    bus.slot_clr      = (state_q == StLoad);
    bus.slot_clr_addr = (state_q == StLoad) ? slot_q : '0;
    bus.busy          = (state_q != StIdle) && (state_q != StBill);
    bus.current_floor = floor_q;
    bus.moving        = ((state_q == StLoad) || (state_q == StTravelDown)) ? plate_q : PlateEmpty;
    bus.plate_type    = plate_type_q;
    bus.fee           = fee_q;
    bus.done          = (state_q == StBill);
    bus.not_found     = not_found_q;
  end

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed bench for the exit controller with a registered slot-table model.
module tb_parking_exit_controller;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parking_exit_if bus ();

  parking_exit_controller #(
    .NUM_SLOTS    (14),
    .FLOOR_CYCLES (4),
    .UNIT_SHIFT   (4),
    .SEDAN_RATE   (2),
    .SUV_RATE     (3)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  logic [31:0] mem [14];

  always @(posedge clk) begin
    if (rst) bus.slot_rd_data <= '0;
    else if (bus.slot_rd_en) bus.slot_rd_data <= mem[bus.slot_rd_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int r_rd, r_rd_max, r_first_rd, r_f3, r_clr, r_clr_addr, r_clr_cyc, r_clr_floor;
  int r_mov, r_mov_bad, r_done, r_done_cyc, r_fee, r_type, r_nf, r_nf_cyc, r_floor_at;
  int r_busy_end;

  // Cycle 0 is the first cycle after the request is sampled
  task automatic run_req(input logic [15:0] plate, input int leak_off, input int inj_cyc,
                         input int snap_cyc, input int budget);
    int ended;
    r_rd = 0; r_rd_max = -1; r_first_rd = -1; r_f3 = -1; r_clr = 0; r_clr_addr = -1;
    r_clr_cyc = -1; r_clr_floor = -1; r_mov = 0; r_mov_bad = 0; r_done = 0; r_done_cyc = -1;
    r_fee = -1; r_type = -1; r_nf = 0; r_nf_cyc = -1; r_floor_at = -1;
    ended = -1;
    @(posedge clk); #1;
    bus.out_mode = 1'b1;
    bus.license_plate = plate;
    @(posedge clk); #1;
    bus.out_mode = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.slot_rd_en) begin
        r_rd++;
        if (int'(bus.slot_rd_addr) > r_rd_max) r_rd_max = int'(bus.slot_rd_addr);
        if (r_first_rd < 0) r_first_rd = c;
      end
      if (bus.current_floor == 3'd3 && r_f3 < 0) r_f3 = c;
      if (bus.slot_clr) begin
        r_clr++;
        r_clr_addr = int'(bus.slot_clr_addr);
        r_clr_cyc = c;
        r_clr_floor = int'(bus.current_floor);
      end
      if (bus.moving != 16'h0) begin
        r_mov++;
        if (bus.moving != plate) r_mov_bad++;
      end
      if (bus.done) begin
        r_done++;
        r_done_cyc = c;
        r_fee = int'(bus.fee);
        r_type = int'(bus.plate_type);
      end
      if (bus.not_found) begin
        r_nf++;
        r_nf_cyc = c;
      end
      if (c == snap_cyc) r_floor_at = int'(bus.current_floor);
      if (c == leak_off) bus.leakage = 1'b0;
      if (c == inj_cyc) begin
        bus.out_mode = 1'b1;
        bus.license_plate = 16'h8ABC;
      end else if (c == inj_cyc + 1) begin
        bus.out_mode = 1'b0;
      end
      if ((r_done > 0 || r_nf > 0) && ended < 0) ended = c;
      if (ended >= 0 && c >= ended + 3) break;
    end
    if (ended < 0) check_eq("timeout", 32'd1, 32'd0);
    r_busy_end = int'(bus.busy);
  endtask

  task automatic fill_others();
    for (int i = 0; i < 14; i++) mem[i] = {16'h0000, 16'h1000 + 16'(i)};
  endtask

  initial begin
    int reached;
    bus.out_mode = 1'b0;
    bus.license_plate = '0;
    bus.leakage = 1'b0;
    bus.leakage_floor = '0;
    bus.time_now = '0;
    for (int i = 0; i < 14; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_floor", 32'(bus.current_floor), 32'd0);
    check_eq("rst_moving", 32'(bus.moving), 32'd0);
    check_eq("rst_fee", 32'(bus.fee), 32'd0);
    check_eq("rst_flags", {28'd0, bus.done, bus.not_found, bus.slot_clr, bus.slot_rd_en},
             32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SUV in slot 5 (floor 3)
    mem[5] = {16'h0010, 16'h8ABC};
    bus.time_now = 16'h0050;
    run_req(16'h8ABC, -1, -1, -1, 300);
    check_eq("t1_reads", r_rd, 6);
    check_eq("t1_rd_max", r_rd_max, 5);
    check_eq("t1_first_rd", r_first_rd, 0);
    check_eq("t1_floor3_cyc", r_f3, 19);
    check_eq("t1_clr_cnt", r_clr, 1);
    check_eq("t1_clr_addr", r_clr_addr, 5);
    check_eq("t1_clr_cyc", r_clr_cyc, 21);
    check_eq("t1_clr_floor", r_clr_floor, 3);
    check_eq("t1_moving_cyc", r_mov, 14);
    check_eq("t1_moving_val", r_mov_bad, 0);
    check_eq("t1_done_cnt", r_done, 1);
    check_eq("t1_done_cyc", r_done_cyc, 35);
    check_eq("t1_fee", r_fee, 15);
    check_eq("t1_type", r_type, 1);
    check_eq("t1_busy_end", r_busy_end, 0);

    // Sedan across timebase wrap; second request while busy must be ignored
    mem[0] = {16'hFFF0, 16'h1234};
    bus.time_now = 16'h0010;
    run_req(16'h1234, -1, 3, -1, 300);
    check_eq("t2_reads", r_rd, 1);
    check_eq("t2_done_cnt", r_done, 1);
    check_eq("t2_done_cyc", r_done_cyc, 14);
    check_eq("t2_fee", r_fee, 6);
    check_eq("t2_type", r_type, 0);
    check_eq("t2_clr_addr", r_clr_addr, 0);
    check_eq("t2_clr_cnt", r_clr, 1);

    // SUV fee saturation
    mem[2] = {16'h0000, 16'hC001};
    bus.time_now = 16'hFFFF;
    run_req(16'hC001, -1, -1, -1, 300);
    check_eq("t3_fee", r_fee, 255);
    check_eq("t3_type", r_type, 1);
    check_eq("t3_clr_addr", r_clr_addr, 2);

    // Absent plate with a full table
    fill_others();
    run_req(16'h4444, -1, -1, -1, 300);
    check_eq("t4_reads", r_rd, 14);
    check_eq("t4_rd_max", r_rd_max, 13);
    check_eq("t4_nf_cnt", r_nf, 1);
    check_eq("t4_nf_cyc", r_nf_cyc, 15);
    check_eq("t4_clr_cnt", r_clr, 0);
    check_eq("t4_done_cnt", r_done, 0);
    check_eq("t4_busy_end", r_busy_end, 0);

    // Leak on floor 7 holds the car for 20 HOLD_CHECK cycles
    mem[13] = {16'h0000, 16'h2222};
    bus.time_now = 16'h0100;
    bus.leakage = 1'b1;
    bus.leakage_floor = 3'd7;
    run_req(16'h2222, 63, -1, 63, 400);
    check_eq("t5_floor_held", r_floor_at, 7);
    check_eq("t5_clr_cnt", r_clr, 1);
    check_eq("t5_clr_cyc", r_clr_cyc, 64);
    check_eq("t5_clr_floor", r_clr_floor, 7);
    check_eq("t5_clr_addr", r_clr_addr, 13);
    check_eq("t5_done_cyc", r_done_cyc, 94);
    check_eq("t5_fee", r_fee, 34);

    // Reset during TRAVEL_UP at floor 2
    bus.leakage = 1'b0;
    fill_others();
    mem[5] = {16'h0010, 16'h8ABC};
    @(posedge clk); #1;
    bus.out_mode = 1'b1;
    bus.license_plate = 16'h8ABC;
    @(posedge clk); #1;
    bus.out_mode = 1'b0;
    reached = 0;
    r_clr = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.slot_clr) r_clr++;
      if (bus.current_floor == 3'd2) begin
        reached = 1;
        break;
      end
    end
    check_eq("t6_reach_f2", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    if (bus.slot_clr) r_clr++;
    check_eq("t6_floor", 32'(bus.current_floor), 32'd0);
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.slot_clr) r_clr++;
    end
    check_eq("t6_clr_cnt", r_clr, 0);
    check_eq("t6_busy_after", 32'(bus.busy), 32'd0);

    // Empty-marker plate
    run_req(16'h0000, -1, -1, -1, 50);
    check_eq("t7_nf_cnt", r_nf, 1);
    check_eq("t7_nf_cyc", r_nf_cyc, 0);
    check_eq("t7_reads", r_rd, 0);
    check_eq("t7_busy_end", r_busy_end, 0);
    check_eq("t7_done_cnt", r_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
